// File: rtl/sisc_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module   : sisc_dmem_resp
// Purpose  : Data-memory responder with a valid/ready request, fixed wait
//            states and a one-cycle response pulse. The optional bounds
//            check is enabled by defining DMEM_BOUNDS_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sisc_dmem_resp #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
`ifdef DMEM_BOUNDS_CHK_EN
  output logic              rsp_err,
`endif
  output logic              busy
);

  localparam int         IDX_W      = $clog2(DEPTH);
  localparam logic [3:0] C_CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                w_hs;
  logic                w_commit;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [IDX_W-1:0]    w_idx;
  logic                w_oob;

  assign w_hs = (state_q == S_IDLE) && req_valid && !rst;

  // With zero wait states the array is accessed on the handshake edge itself,
  // before the holding registers are loaded, so the request is used directly.
  assign w_commit = !rst && (((state_q == S_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                             ((state_q == S_WAIT) && (cnt_q == 4'd0)));
  assign w_we    = (state_q == S_IDLE) ? req_we    : we_q;
  assign w_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign w_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
  assign w_idx   = w_addr[IDX_W-1:0];

`ifdef DMEM_BOUNDS_CHK_EN
  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);
  logic err_q;

  assign w_oob   = ({1'b0, w_addr} >= C_DEPTH);
  assign rsp_err = rsp_valid && err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (w_commit) begin
      err_q <= w_oob;
    end
  end
`else
  logic w_unused_addr;

  assign w_oob         = 1'b0;
  assign w_unused_addr = ^w_addr;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = C_CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_commit) begin
        rdata_q <= (w_we || w_oob) ? '0 : mem_q[w_idx];
      end
    end
  end

  // Array and holding registers carry no reset; rst only blocks the commit.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
    if (w_commit && w_we && !w_oob) begin
      mem_q[w_idx] <= w_wdata;
    end
  end

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rsp_rdata = rdata_q;

endmodule
`default_nettype wire
